// File: rtl/trigger_io_ctrl.sv
// trigger_io_ctrl: synchronises and debounces the trigger button, fires a
// 1-cycle trigger pulse into the register file (sets t0) and then holds off
// until the program clears t0 and the button is released. Independently it
// keeps a registered display copy of a0 and strobes whenever it changes.
//
// Ports:
//   clk      in   system clock, all state on posedge
//   rst_n    in   asynchronous active-low reset
//   btn_i    in   raw button, asynchronous to clk, active-high
//   t0_i     in   current t0 register value (only bit 0 examined)
//   a0_i     in   current a0 register value
//   trigger  out  1-cycle pulse into the register file (sets t0)
//   busy     out  high in every FSM state except IDLE
//   a0_disp  out  registered copy of a0 for display
//   a0_chg   out  1-cycle strobe: a0_disp updated this cycle
module trigger_io_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_i,
    input  logic [DATA_WIDTH-1:0] t0_i,
    input  logic [DATA_WIDTH-1:0] a0_i,
    output logic                  trigger,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] a0_disp,
    output logic                  a0_chg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_SETTLE,
        S_WAIT_ACK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_stable;
    logic                  r_stable_d;
    logic [CNT_WIDTH-1:0]  r_cnt;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_press;
    logic                  w_t0_set;
    logic                  w_unused_t0;
    logic [DATA_WIDTH-1:0] r_a0_disp;
    logic                  r_a0_chg;

    // Two-flop synchroniser; r_sync2 is the clean btn_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while btn_s disagrees with the accepted level,
    // so any return to the old level restarts the qualification window.
    // It stops at LP_CNT_MAX because acceptance clears it on that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_press  = r_stable & ~r_stable_d;
    assign w_t0_set = t0_i[0];

    // Upper t0 bits carry unrelated register contents.
    assign w_unused_t0 = ^t0_i[DATA_WIDTH-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Presses seen outside IDLE are simply ignored; since WAIT_ACK only
    // exits with the button released, a held button cannot retrigger.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!w_t0_set && !r_stable) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Pure decode of the state register: one cycle wide, and it drops
    // at once on async reset.
    assign trigger = (r_state == S_FIRE);
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0_disp <= '0;
            r_a0_chg  <= 1'b0;
        end else if (a0_i != r_a0_disp) begin
            r_a0_disp <= a0_i;
            r_a0_chg  <= 1'b1;
        end else begin
            r_a0_chg  <= 1'b0;
        end
    end

    assign a0_disp = r_a0_disp;
    assign a0_chg  = r_a0_chg;

endmodule

// File: tb/tb_trigger_io_ctrl.sv
// Randomised plus directed bench for trigger_io_ctrl against a
// behavioural model of the button / handshake / a0 display rules.
module tb_trigger_io_ctrl;

    localparam int DW  = 32;
    localparam int DEB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_i = 1'b0;
    logic [DW-1:0] t0_i = '0;
    logic [DW-1:0] a0_i = '0;
    logic          trigger;
    logic          busy;
    logic [DW-1:0] a0_disp;
    logic          a0_chg;

    always #5 clk = ~clk;

    trigger_io_ctrl #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DEB)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_i),
        .t0_i    (t0_i),
        .a0_i    (a0_i),
        .trigger (trigger),
        .busy    (busy),
        .a0_disp (a0_disp),
        .a0_chg  (a0_chg)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: btn_s is btn_i delayed two samples; the accepted
    // level flips once the last DEB samples of btn_s all disagree with it.
    typedef enum int {P_IDLE, P_FIRE, P_SETTLE, P_WAIT} phase_e;
    bit            m_s1, m_s2, m_st, m_st_d;
    bit            hist[$];
    phase_e        m_ph;
    logic [DW-1:0] m_disp;
    bit            m_chg;

    int  ntrig   = 0;
    bit  auto_t0 = 1'b1;
    int  t0_cnt  = 0;

    function automatic void m_reset();
        m_s1 = 0; m_s2 = 0; m_st = 0; m_st_d = 0;
        hist.delete();
        m_ph = P_IDLE;
        m_disp = '0;
        m_chg = 0;
    endfunction

    function automatic void m_edge();
        bit     all_diff;
        bit     nst;
        bit     press;
        phase_e nph;
        nst   = m_st;
        press = m_st && !m_st_d;
        nph   = m_ph;
        hist.push_back(m_s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        all_diff = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] == m_st) all_diff = 0;
        if (all_diff) begin
            nst = m_s2;
            hist.delete();
        end
        case (m_ph)
            P_IDLE:   if (press) nph = P_FIRE;
            P_FIRE:   nph = P_SETTLE;
            P_SETTLE: nph = P_WAIT;
            default:  if (!t0_i[0] && !m_st) nph = P_IDLE;
        endcase
        m_st_d = m_st;
        m_st   = nst;
        m_s2   = m_s1;
        m_s1   = btn_i;
        if (a0_i != m_disp) begin
            m_disp = a0_i;
            m_chg  = 1;
        end else begin
            m_chg  = 0;
        end
        m_ph = nph;
    endfunction

    task automatic chk_outs();
        chk("trigger", {31'b0, trigger}, {31'b0, m_ph == P_FIRE});
        chk("busy",    {31'b0, busy},    {31'b0, m_ph != P_IDLE});
        chk("a0_disp", a0_disp,          m_disp);
        chk("a0_chg",  {31'b0, a0_chg},  {31'b0, m_chg});
    endtask

    // One clock: model steps on the edge, outputs checked on the negedge,
    // then the register-file stand-in updates t0.
    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        @(negedge clk);
        chk_outs();
        if (trigger) begin
            ntrig++;
            t0_i   = $urandom;
            t0_i[0] = 1'b1;
            t0_cnt = $urandom_range(0, 50);
        end else if (auto_t0 && t0_i[0]) begin
            if (t0_cnt == 0) t0_i[0] = 1'b0;
            else t0_cnt--;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    int base;
    int lat;

    initial begin
        m_reset();
        // Reset state with button held and a0 pending.
        btn_i = 1'b1;
        a0_i  = 32'hDEAD;
        #12;
        chk_outs();
        chk("rst_trig", {31'b0, trigger}, 32'd0);
        chk("rst_disp", a0_disp, 32'd0);
        @(negedge clk);
        btn_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rel_disp", a0_disp, 32'hDEAD);
        chk("rel_chg", {31'b0, a0_chg}, 32'd1);
        repeat (30) tick();

        // Clean press: pulse after 2 + DEB + 1 cycles.
        auto_t0 = 1'b1;
        base = ntrig;
        btn_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (trigger && lat == 0) lat = i;
        end
        chk("press_lat", lat, 2 + DEB + 1);
        chk("press_cnt", ntrig - base, 1);
        btn_i = 1'b0;
        wait_idle("press_idle");
        repeat (5) tick();

        // Glitch shorter than the debounce window.
        base = ntrig;
        btn_i = 1'b1;
        repeat (10) tick();
        btn_i = 1'b0;
        repeat (30) tick();
        chk("glitch_cnt", ntrig - base, 0);
        chk("glitch_busy", {31'b0, busy}, 32'd0);

        // Handshake: t0 clear first, release later; then the reverse.
        auto_t0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            base = ntrig;
            btn_i = 1'b1;
            for (int i = 1; i <= 60; i++) begin
                tick();
                if (i == 30) begin
                    if (k == 0) t0_i[0] = 1'b0;
                    else btn_i = 1'b0;
                end
            end
            chk("hs_busy_mid", {31'b0, busy}, 32'd1);
            if (k == 0) btn_i = 1'b0;
            else t0_i[0] = 1'b0;
            wait_idle("hs_idle");
            repeat (40) tick();
            chk("hs_cnt", ntrig - base, 1);
        end

        // Second press while busy is dropped; fresh press afterwards fires.
        base = ntrig;
        btn_i = 1'b1;
        repeat (30) tick();
        btn_i = 1'b0;
        repeat (25) tick();
        btn_i = 1'b1;
        repeat (30) tick();
        chk("busy_drop", ntrig - base, 1);
        btn_i = 1'b0;
        t0_i[0] = 1'b0;
        wait_idle("busy_idle");
        btn_i = 1'b1;
        repeat (30) tick();
        chk("fresh_cnt", ntrig - base, 2);
        btn_i = 1'b0;
        t0_i[0] = 1'b0;
        wait_idle("fresh_idle");
        auto_t0 = 1'b1;

        // Async reset in the FIRE cycle.
        base = ntrig;
        btn_i = 1'b1;
        lat = 0;
        while (!trigger && lat < 60) begin
            tick();
            lat++;
        end
        chk("fire_seen", {31'b0, trigger}, 32'd1);
        #1;
        rst_n = 1'b0;
        btn_i = 1'b0;
        t0_i  = '0;
        m_reset();
        #1;
        chk("rst_fire_trig", {31'b0, trigger}, 32'd0);
        chk("rst_fire_busy", {31'b0, busy}, 32'd0);
        base = ntrig;
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("rst_no_pulse", ntrig - base, 0);

        // a0 changing every cycle.
        for (int i = 0; i < 6; i++) begin
            a0_i = a0_i + 32'd1;
            tick();
            chk("a0_every", {31'b0, a0_chg}, 32'd1);
        end

        // Randomised segments of button levels with random a0 traffic.
        repeat (150) begin
            int len;
            len   = $urandom_range(1, 40);
            btn_i = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) a0_i = $urandom;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
